// File: rtl/sdram_read_stream.sv
// sdram_read_stream: Wishbone master that reads WORDS consecutive 32-bit words
// from SDRAM starting at BASE_ADDR and streams them out through a small FIFO
// with a valid/ready handshake. One Wishbone transaction is outstanding at a
// time, and a request is only issued when the FIFO has room for its word.
module sdram_read_stream #(
  parameter logic [31:0] BASE_ADDR  = 32'd0,
  parameter int          WORDS      = 120,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        CLKOUT,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        cyc_i,
  output logic        stb_i,
  output logic        we_i,
  output logic [3:0]  sel_i,
  output logic [31:0] addr_i,
  output logic [31:0] data_i,
  input  logic [31:0] data_o,
  input  logic        stall_o,
  input  logic        sdram_ack,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int RW = $clog2(WORDS + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [RW-1:0] WORDS_C = RW'(WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ACK,
    S_RELEASE,
    S_DRAIN
  } state_t;

  state_t        r_state;
  logic          r_cyc;
  logic [31:0]   r_addr;
  logic [RW-1:0] r_remaining;
  logic          r_busy;
  logic          r_done;

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_next;
  logic          w_space;

  // Wishbone outputs come straight from registers; the constant ones are tied off.
  assign cyc_i     = r_cyc;
  assign stb_i     = r_cyc;
  assign we_i      = 1'b0;
  assign sel_i     = 4'b1111;
  assign data_i    = 32'd0;
  assign addr_i    = r_addr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];

  // A word is accepted only while our own request is pending and not stalled;
  // acks arriving in any other state are ignored.
  assign w_push = (r_state == S_WAIT_ACK) && sdram_ack && !stall_o;
  assign w_pop  = out_valid && out_ready;

  // Occupancy after this edge; space for a new request is judged on it so a
  // pop in the same cycle immediately frees a slot.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  assign w_space = (w_count_next < DEPTH_C);

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // FIFO storage; cleared on reset so the head word reads as zero when empty.
  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= data_o;
    end
  end

  // Control FSM: issue one read at a time, drop cyc for a cycle after each ack,
  // and finish once the last word has been consumed from the FIFO.
  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cyc       <= 1'b0;
      r_addr      <= BASE_ADDR;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A start coinciding with the done pulse still belongs to the old block.
          if (start && !r_done) begin
            r_state     <= S_REQ;
            r_addr      <= BASE_ADDR;
            r_remaining <= WORDS_C;
            r_busy      <= 1'b1;
          end
        end
        S_REQ: begin
          if (w_space) begin
            r_cyc   <= 1'b1;
            r_state <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (w_push) begin
            r_cyc       <= 1'b0;
            r_remaining <= r_remaining - RW'(1);
            r_addr      <= r_addr + 32'd1;
            r_state     <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // The request check is folded in here so cyc rises straight after
          // the single low cycle when there is room; otherwise park in REQ.
          if (r_remaining != '0) begin
            if (w_space) begin
              r_cyc   <= 1'b1;
              r_state <= S_WAIT_ACK;
            end else begin
              r_state <= S_REQ;
            end
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_count == '0) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cyc   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_read_stream.sv
// Bench for sdram_read_stream: two instances (8-word block at address 0, and a
// single word at 32'hFFFFFFFF), a small SDRAM model per instance, and a
// scoreboard of expected words and addresses filled when a start is issued.
module tb_sdram_read_stream;

  localparam int          W0    = 8;
  localparam logic [31:0] B0    = 32'd0;
  localparam int          W1    = 1;
  localparam logic [31:0] B1    = 32'hFFFFFFFF;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start     [2];
  logic        busy      [2];
  logic        done      [2];
  logic        cyc       [2];
  logic        stb       [2];
  logic        we        [2];
  logic [3:0]  sel       [2];
  logic [31:0] addr      [2];
  logic [31:0] wdat      [2];
  logic [31:0] rdata     [2];
  logic        stall     [2];
  logic        ack       [2];
  logic        m_ack     [2];
  logic        force_ack [2];
  logic [31:0] odata     [2];
  logic        ovalid    [2];
  logic        oready    [2];
  int          m_cnt     [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_data[$];
  logic [31:0] exp_addr[$];
  int          rise_cyc[$];
  int          cyc_count = 0;
  logic        cyc_prev = 1'b0;
  int          acks_seen = 0;
  int          done_seen = 0;

  sdram_read_stream #(.BASE_ADDR(B0), .WORDS(W0), .FIFO_DEPTH(DEPTH)) u_dut0 (
    .CLKOUT(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]), .sel_i(sel[0]), .addr_i(addr[0]),
    .data_i(wdat[0]), .data_o(rdata[0]), .stall_o(stall[0]), .sdram_ack(ack[0]),
    .out_data(odata[0]), .out_valid(ovalid[0]), .out_ready(oready[0])
  );

  sdram_read_stream #(.BASE_ADDR(B1), .WORDS(W1), .FIFO_DEPTH(DEPTH)) u_dut1 (
    .CLKOUT(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]), .sel_i(sel[1]), .addr_i(addr[1]),
    .data_i(wdat[1]), .data_o(rdata[1]), .stall_o(stall[1]), .sdram_ack(ack[1]),
    .out_data(odata[1]), .out_valid(ovalid[1]), .out_ready(oready[1])
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hA000 + a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // SDRAM model: ack rises 7 edges after cyc rises and stays up until cyc drops.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ack[i] = m_ack[i] | force_ack[i];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_cnt[i] <= 0;
        m_ack[i] <= 1'b0;
        rdata[i] <= 32'd0;
      end else if (!cyc[i]) begin
        m_cnt[i] <= 0;
        m_ack[i] <= 1'b0;
      end else if (!m_ack[i]) begin
        if (m_cnt[i] == 6) begin
          m_ack[i] <= 1'b1;
          rdata[i] <= word_of(addr[i]);
        end else begin
          m_cnt[i] <= m_cnt[i] + 1;
        end
      end
    end
  end

  always @(posedge clk) cyc_count++;

  // Monitor for instance 0, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      cyc_prev = 1'b0;
    end else begin
      if (cyc[0] && !cyc_prev) rise_cyc.push_back(cyc_count);
      cyc_prev = cyc[0];
      if (ovalid[0] && oready[0]) begin
        if (exp_data.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pop_unexpected actual=%h expected=none", odata[0]);
        end else begin
          check("out_data", odata[0], exp_data.pop_front());
        end
      end
      if (cyc[0] && ack[0] && !stall[0]) begin
        acks_seen++;
        if (exp_addr.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL ack_unexpected actual=%h expected=none", addr[0]);
        end else begin
          check("addr_i", addr[0], exp_addr.pop_front());
        end
        check("we_i", {31'd0, we[0]}, 32'd0);
        check("sel_i", {28'd0, sel[0]}, 32'hF);
      end
      if (done[0]) begin
        done_seen++;
        check("done_fifo_empty", exp_data.size(), 32'd0);
        check("done_busy", {31'd0, busy[0]}, 32'd0);
      end
    end
  end

  typedef struct {
    int hold;           // cycles with out_ready low after start
    bit stall;          // stall the first ack for 5 cycles
    bit second_start;   // pulse start again while busy
    bit rand_ready;     // random out_ready while draining
    bit spurious;       // ack while idle before start
    bit check_period;   // measure cyc-to-cyc period
    int exp_hold_acks;  // acks expected while out_ready is low
    int exp_words;      // words expected per block
    int exp_dones;      // done pulses expected
  } vec_t;

  vec_t vecs[5];

  task automatic pulse_start(input int ch);
    @(posedge clk); #1 start[ch] = 1'b1;
    @(posedge clk); #1 start[ch] = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] held;
    bool_wait: begin end
    acks_seen = 0;
    done_seen = 0;
    rise_cyc.delete();
    oready[0] = (v.hold == 0);
    if (v.spurious) begin
      @(posedge clk); #1 force_ack[0] = 1'b1;
      @(posedge clk); #1 force_ack[0] = 1'b0;
      @(negedge clk);
      check("spurious_no_push", {31'd0, ovalid[0]}, 32'd0);
      check("spurious_idle", {31'd0, busy[0]}, 32'd0);
    end
    for (int k = 0; k < v.exp_words; k++) begin
      exp_addr.push_back(B0 + k);
      exp_data.push_back(word_of(B0 + k));
    end
    pulse_start(0);
    @(negedge clk);
    check("start_busy", {31'd0, busy[0]}, 32'd1);
    check("start_cyc_low", {31'd0, cyc[0]}, 32'd0);
    @(negedge clk);
    check("start_cyc_high", {30'd0, cyc[0], stb[0]}, 32'd3);
    check("start_addr", addr[0], B0);
    if (v.stall) begin
      int c;
      for (c = 0; c < 50; c++) begin
        @(posedge clk); #1;
        if (ack[0]) break;
      end
      if (c == 50) fail_now("stall_wait_ack");
      stall[0] = 1'b1;
      held = addr[0];
      for (int s = 0; s < 5; s++) begin
        @(negedge clk);
        check("stall_addr_held", addr[0], held);
        check("stall_cyc_held", {30'd0, cyc[0], stb[0]}, 32'd3);
        check("stall_no_push", {31'd0, ovalid[0]}, 32'd0);
      end
      @(posedge clk); #1 stall[0] = 1'b0;
    end
    if (v.second_start) begin
      repeat (20) @(posedge clk);
      pulse_start(0);
    end
    if (v.hold > 0) begin
      repeat (v.hold) @(posedge clk);
      #1;
      check("hold_acks", acks_seen, v.exp_hold_acks);
      check("hold_cyc_low", {31'd0, cyc[0]}, 32'd0);
      check("hold_valid", {31'd0, ovalid[0]}, 32'd1);
      oready[0] = 1'b1;
    end
    for (int c = 0; c < 3000 && done_seen == 0; c++) begin
      @(posedge clk); #1;
      if (v.rand_ready) oready[0] = 1'($urandom_range(0, 1));
    end
    if (done_seen == 0) fail_now("wait_done");
    oready[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("done_count", done_seen, v.exp_dones);
    check("ack_count", acks_seen, v.exp_words);
    check("words_left", exp_data.size(), 32'd0);
    check("end_busy", {31'd0, busy[0]}, 32'd0);
    if (v.check_period) begin
      if (rise_cyc.size() < 2) fail_now("period_rises");
      else check("word_period", rise_cyc[1] - rise_cyc[0], 32'd9);
    end
  endtask

  initial begin
    vecs[0] = '{hold: 0,   stall: 0, second_start: 0, rand_ready: 0, spurious: 0, check_period: 1,
                exp_hold_acks: 0, exp_words: W0, exp_dones: 1};
    vecs[1] = '{hold: 200, stall: 0, second_start: 0, rand_ready: 0, spurious: 0, check_period: 0,
                exp_hold_acks: DEPTH, exp_words: W0, exp_dones: 1};
    vecs[2] = '{hold: 0,   stall: 0, second_start: 1, rand_ready: 0, spurious: 0, check_period: 0,
                exp_hold_acks: 0, exp_words: W0, exp_dones: 1};
    vecs[3] = '{hold: 0,   stall: 1, second_start: 0, rand_ready: 0, spurious: 1, check_period: 0,
                exp_hold_acks: 0, exp_words: W0, exp_dones: 1};
    vecs[4] = '{hold: 0,   stall: 0, second_start: 0, rand_ready: 1, spurious: 0, check_period: 0,
                exp_hold_acks: 0, exp_words: W0, exp_dones: 1};

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      stall[i] = 1'b0;
      force_ack[i] = 1'b0;
      oready[i] = 1'b0;
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_cyc_stb", {30'd0, cyc[0], stb[0]}, 32'd0);
    check("rst_we", {31'd0, we[0]}, 32'd0);
    check("rst_sel", {28'd0, sel[0]}, 32'hF);
    check("rst_addr0", addr[0], B0);
    check("rst_addr1", addr[1], B1);
    check("rst_data_i", wdat[0], 32'd0);
    check("rst_busy_done", {30'd0, busy[0], done[0]}, 32'd0);
    check("rst_out_valid", {31'd0, ovalid[0]}, 32'd0);
    check("rst_out_data", odata[0], 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int r = 0; r < 5; r++) begin
      run_vec(vecs[r]);
    end

    // Reset while a read is outstanding.
    acks_seen = 0;
    oready[0] = 1'b0;
    for (int k = 0; k < W0; k++) begin
      exp_addr.push_back(B0 + k);
      exp_data.push_back(word_of(B0 + k));
    end
    pulse_start(0);
    begin
      int c;
      for (c = 0; c < 200; c++) begin
        @(negedge clk);
        if (acks_seen == 2 && cyc[0]) break;
      end
      if (c == 200) fail_now("reset_wait_req");
    end
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("arst_cyc_stb", {30'd0, cyc[0], stb[0]}, 32'd0);
    check("arst_out_valid", {31'd0, ovalid[0]}, 32'd0);
    check("arst_busy", {31'd0, busy[0]}, 32'd0);
    exp_addr.delete();
    exp_data.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1 force_ack[0] = 1'b1;
    @(posedge clk); #1 force_ack[0] = 1'b0;
    @(negedge clk);
    check("post_rst_ack_ignored", {29'd0, ovalid[0], busy[0], cyc[0]}, 32'd0);
    run_vec(vecs[0]);

    // Single word at the top of the address space.
    pulse_start(1);
    begin
      int c;
      for (c = 0; c < 50; c++) begin
        @(negedge clk);
        if (cyc[1] && ack[1]) break;
      end
      if (c == 50) fail_now("wrap_wait_ack");
    end
    check("wrap_addr", addr[1], B1);
    @(negedge clk);
    check("wrap_valid", {31'd0, ovalid[1]}, 32'd1);
    check("wrap_data", odata[1], word_of(B1));
    check("wrap_addr_next", addr[1], 32'd0);
    check("wrap_cyc_low", {31'd0, cyc[1]}, 32'd0);
    repeat (5) @(negedge clk);
    check("wrap_no_early_done", {30'd0, busy[1], done[1]}, 32'd2);
    @(posedge clk); #1 oready[1] = 1'b1;
    begin
      int c;
      for (c = 0; c < 20; c++) begin
        @(negedge clk);
        if (done[1]) break;
      end
      if (c == 20) fail_now("wrap_wait_done");
      else check("wrap_done_state", {30'd0, busy[1], ovalid[1]}, 32'd0);
    end
    @(negedge clk);
    check("wrap_done_pulse", {30'd0, busy[1], done[1]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_read_stream.md
# sdram_read_stream

Wishbone master that reads a block of `WORDS` 32-bit words from SDRAM, starting at `BASE_ADDR`, and streams them to the ConvNet input through a small internal FIFO with a valid/ready handshake. It sits downstream of `read_to_sdram`. That block fills SDRAM from the FX2 slave FIFO, and this one drains it into the compute pipeline. It uses the same per-word Wishbone cycle protocol and the same SDRAM-side signal names, so it can share the SDRAM port through the existing arbiter.

## Interface
- `BASE_ADDR`, 32'd0: first word address. Word addressing: increment by 1 per word.
- `WORDS`, 120: number of words per burst request, at least 1.
- `FIFO_DEPTH`, 4: output FIFO entries. Must be a power of 2, at least 2.
- `CLKOUT` input, 1 bit: the only clock. All logic runs on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: one-cycle request to begin a block read. Ignored while `busy`.
- `busy` output, 1 bit: high from the cycle after an accepted `start` until the cycle `done` pulses.
- `done` output, 1 bit: one-cycle pulse when the last word has left the FIFO.
- `cyc_i`, `stb_i` outputs, 1 bit each: Wishbone cycle and strobe.
- `we_i` output, 1 bit: constant 0.
- `sel_i` output, 4 bits: constant 4'b1111.
- `addr_i` output, 32 bits: read address.
- `data_i` output, 32 bits: constant 0.
- `data_o` input, 32 bits: SDRAM read data. Valid only while `sdram_ack` is high.
- `stall_o` input, 1 bit: SDRAM stall.
- `sdram_ack` input, 1 bit: SDRAM acknowledge.
- `out_data` output, 32 bits: FIFO head word.
- `out_valid` output, 1 bit: FIFO not empty.
- `out_ready` input, 1 bit: consumer accepts the head word when `out_valid` and `out_ready` are both high.

## Operation
- FSM states: IDLE, REQ, WAIT_ACK, RELEASE, DRAIN.
- IDLE:
  - `start` → REQ. Load `addr_i`=`BASE_ADDR` and remaining count=`WORDS`. Set `busy`=1.
- REQ:
  - Entered only when FIFO count < `FIFO_DEPTH`. Otherwise hold, with `cyc_i`=`stb_i`=0.
  - When there is space, assert `cyc_i`=`stb_i`=1 together → WAIT_ACK.
- WAIT_ACK:
  - Hold `cyc_i`, `stb_i` and `addr_i` stable while `stall_o`=1 or `sdram_ack`=0.
  - On `sdram_ack`=1 with `stall_o`=0: push `data_o` into the FIFO, decrement the remaining count, increment `addr_i` → RELEASE.
- RELEASE:
  - `cyc_i`=`stb_i`=0 for exactly one cycle. The SDRAM model needs `cyc_i` low to leave its ACK state.
  - Then go to REQ if remaining > 0, else DRAIN.
- DRAIN:
  - Wait until the FIFO is empty, then pulse `done`, clear `busy` → IDLE.
- Only one outstanding transaction at a time. Space is checked at REQ entry, so a push never overflows.
- `sdram_ack` outside WAIT_ACK is ignored: no push, no state change.
- FIFO:
  - Push and pop in the same cycle leaves the count unchanged and is legal at any count, including full.
  - Pop when empty is impossible because `out_valid`=0.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- Address arithmetic is 32-bit modulo; wrap past 32'hFFFFFFFF is allowed.
- Remaining-count width is `$clog2(WORDS+1)` bits.
- `start` during `busy` (including in the `done` cycle) is dropped and not queued.
- Reset mid-transaction:
  - `cyc_i`/`stb_i` drop asynchronously.
  - FIFO contents are discarded.
  - Any in-flight ack after reset is ignored.

## Timing
- Reset values: `cyc_i`=0, `stb_i`=0, `we_i`=0, `sel_i`=4'b1111, `addr_i`=`BASE_ADDR`, `data_i`=0, `busy`=0, `done`=0, `out_valid`=0, `out_data`=0. FSM in IDLE, FIFO empty.
- `start` sampled at edge N: `busy`=1 and `cyc_i`=`stb_i`=1 after edge N+1 (IDLE→REQ→asserted in REQ).
- Ack sampled at edge M:
  - Word is in the FIFO and `out_valid`=1 after edge M.
  - `cyc_i`=0 for the cycle after edge M.
  - Next `cyc_i` rises after edge M+1.
- All Wishbone outputs are registered. No combinational path from `sdram_ack`/`stall_o` to `cyc_i`/`stb_i`.
- `out_data` is valid in the same cycle as `out_valid`. It changes only after a pop or a push into an empty FIFO.
- With the standard SDRAM model (ack asserted 7 edges after `cyc_i` rises), per-word period is 9 cycles when the FIFO never fills.

## Test plan
- `WORDS`=4, `BASE_ADDR`=0, model preloaded with sdram[k]=32'hA000+k, `out_ready`=1 → `out_data` sequence 32'hA000..32'hA003. `addr_i` observed 0,1,2,3. `we_i` never 1. One `done` pulse, then `busy`=0.
- `out_ready`=0 for 200 cycles, `WORDS`=8, `FIFO_DEPTH`=4 → exactly 4 acks, then `cyc_i` stays 0. Release `out_ready` → remaining 4 words in order, no loss or duplication.
- Second `start` pulsed mid-read → ignored. Exactly `WORDS` transactions; `done` pulses once.
- `rst_n` low during WAIT_ACK → `cyc_i`/`stb_i` are 0 before the next edge and `out_valid`=0. After release, `start` reads from `BASE_ADDR` again correctly.
- `WORDS`=1, `BASE_ADDR`=32'hFFFFFFFF → single read at 32'hFFFFFFFF, `addr_i` wraps to 0 afterwards, `done` after the pop.
- `stall_o`=1 for 5 cycles around the ack, plus a spurious `sdram_ack` while in IDLE → address held during stall, no extra FIFO entry, correct data order.
